// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Packet-level round-robin arbiter sharing the single UART TX FIFO write port
// between NUM_REQ byte-stream requesters. Once granted, a requester keeps
// ownership until its packet ends (last byte, or forced release after
// MAX_PACKET_LEN bytes), so bytes from different packets never interleave.
// The output side is a single registered byte slot that supports a
// simultaneous drain and load, giving 1 byte/cycle throughput.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset (priority over ena)
//   ena        design enable; low freezes all state and forces req_ready low
//   req_data   requester bytes, requester i on [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid  requester byte valid
//   req_last   final byte of a packet
//   req_ready  byte accepted when req_valid[i] & req_ready[i] (combinational)
//   out_data   byte to the TX FIFO
//   out_valid  out_data is valid
//   out_ready  TX FIFO accepts the byte
//   grant      one-hot current owner, zero while idle
//   busy       high while a requester owns the port
//   trunc_err  one-cycle pulse when a packet is force-released at the limit
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 3,
  parameter int MAX_PACKET_LEN = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ena,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          trunc_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_PACKET_LEN + 1);

  // Pointer resets to the highest index so requester 0 is searched first.
  localparam logic [PTR_W-1:0]   PTR_RESET   = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   CNT_LIMIT   = CNT_W'(MAX_PACKET_LEN);
  localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = NUM_REQ'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Registered state
  state_t                 state_r;
  logic [NUM_REQ-1:0]     grant_r;
  logic [PTR_W-1:0]       ptr_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   busy_r;
  logic                   trunc_err_r;
  logic [DATA_WIDTH-1:0]  out_data_r;
  logic                   out_valid_r;

  // Next-state values
  state_t                 state_s;
  logic [NUM_REQ-1:0]     grant_s;
  logic [PTR_W-1:0]       ptr_s;
  logic [CNT_W-1:0]       cnt_s;
  logic                   busy_s;
  logic                   trunc_err_s;
  logic [DATA_WIDTH-1:0]  out_data_s;
  logic                   out_valid_s;

  // Datapath helpers
  logic                   can_load_s;
  logic [NUM_REQ-1:0]     req_ready_s;
  logic                   accept_s;
  logic [DATA_WIDTH-1:0]  sel_data_s;
  logic                   sel_last_s;
  logic [CNT_W-1:0]       cnt_inc_s;
  logic                   at_limit_s;
  logic                   found_s;
  logic [PTR_W-1:0]       winner_s;

  // The output slot can take a new byte when empty or draining this cycle.
  assign can_load_s  = ~out_valid_r | out_ready;
  assign req_ready_s = (ena && (state_r == ST_GRANT) && can_load_s) ? grant_r
                                                                    : {NUM_REQ{1'b0}};
  assign accept_s    = |(req_valid & req_ready_s);
  assign sel_last_s  = |(req_last & grant_r);
  assign cnt_inc_s   = cnt_r + CNT_W'(1);
  assign at_limit_s  = (cnt_inc_s == CNT_LIMIT);

  // One-hot mux of the owner's byte (grant_r is one-hot or zero).
  always_comb begin
    sel_data_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_r[i]) begin
        sel_data_s = sel_data_s | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Round-robin search: first valid requester from ptr_r+1 upward, wrapping.
  always_comb begin
    int sum_v;
    sum_v    = 0;
    found_s  = 1'b0;
    winner_s = ptr_r;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum_v = int'(ptr_r) + k;
      if (sum_v >= NUM_REQ) begin
        sum_v = sum_v - NUM_REQ;
      end else begin
        sum_v = sum_v;
      end
      if (!found_s && req_valid[sum_v]) begin
        found_s  = 1'b1;
        winner_s = PTR_W'(sum_v);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Arbitration FSM next-state logic.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    ptr_s       = ptr_r;
    cnt_s       = cnt_r;
    busy_s      = busy_r;
    trunc_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s = ST_GRANT;
          grant_s = ONE_HOT_LSB << winner_s;
          ptr_s   = winner_s;
          cnt_s   = {CNT_W{1'b0}};
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (accept_s) begin
          cnt_s = cnt_inc_s;
          // A last byte landing exactly on the limit is a clean end.
          if (sel_last_s || at_limit_s) begin
            state_s     = ST_IDLE;
            grant_s     = {NUM_REQ{1'b0}};
            busy_s      = 1'b0;
            trunc_err_s = ~sel_last_s;
          end else begin
            state_s = ST_GRANT;
          end
        end else begin
          state_s = ST_GRANT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        grant_s = {NUM_REQ{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // Output slot next-state: load wins over drain so both can happen together.
  always_comb begin
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    if (accept_s) begin
      out_data_s  = sel_data_s;
      out_valid_s = 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      grant_r     <= {NUM_REQ{1'b0}};
      ptr_r       <= PTR_RESET;
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      trunc_err_r <= 1'b0;
    end else if (ena) begin
      state_r     <= state_s;
      grant_r     <= grant_s;
      ptr_r       <= ptr_s;
      cnt_r       <= cnt_s;
      busy_r      <= busy_s;
      trunc_err_r <= trunc_err_s;
    end
  end

  // Output byte register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (ena) begin
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign req_ready = req_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign grant     = grant_r;
  assign busy      = busy_r;
  assign trunc_err = trunc_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (3 requesters, MAX_PACKET_LEN=4).
// Each requester is fed from a byte queue ({last,data}); a negedge monitor
// records accepted output bytes, grant starts and trunc_err pulses, which the
// scenario tasks compare against hand-written expected sequences.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int DW  = 8;
  localparam int NR  = 3;
  localparam int MPL = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            ena;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            trunc_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [8:0]  q2[$];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [2:0]  glog_q[$];
  logic [2:0]  gexp_q[$];
  int          trunc_cnt;
  logic [2:0]  fire;
  logic [2:0]  prev_grant;

  uart_tx_arbiter #(
    .DATA_WIDTH     (DW),
    .NUM_REQ        (NR),
    .MAX_PACKET_LEN (MPL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ena       (ena),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy),
    .trunc_err (trunc_err)
  );

  always #5 clk = ~clk;

  // Monitor: sample mid-cycle, away from the rising edge.
  initial begin
    fire       = 3'b000;
    prev_grant = 3'b000;
    trunc_cnt  = 0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready & {3{reset_n}};
      if (reset_n && ena && out_valid && out_ready) got_q.push_back(out_data);
      if (grant != 3'b000 && prev_grant == 3'b000) glog_q.push_back(grant);
      prev_grant = grant;
      if (trunc_err && ena) trunc_cnt++;
    end
  end

  // Requester sources: pop accepted bytes and present the next one.
  initial begin
    req_valid = 3'b000;
    req_last  = 3'b000;
    req_data  = {NR*DW{1'b0}};
    forever begin
      @(posedge clk);
      #1;
      if (fire[0] && q0.size() > 0) void'(q0.pop_front());
      if (fire[1] && q1.size() > 0) void'(q1.pop_front());
      if (fire[2] && q2.size() > 0) void'(q2.pop_front());
      if (q0.size() > 0) begin
        req_valid[0] = 1'b1; req_last[0] = q0[0][8]; req_data[7:0] = q0[0][7:0];
      end else begin
        req_valid[0] = 1'b0; req_last[0] = 1'b0; req_data[7:0] = 8'h00;
      end
      if (q1.size() > 0) begin
        req_valid[1] = 1'b1; req_last[1] = q1[0][8]; req_data[15:8] = q1[0][7:0];
      end else begin
        req_valid[1] = 1'b0; req_last[1] = 1'b0; req_data[15:8] = 8'h00;
      end
      if (q2.size() > 0) begin
        req_valid[2] = 1'b1; req_last[2] = q2[0][8]; req_data[23:16] = q2[0][7:0];
      end else begin
        req_valid[2] = 1'b0; req_last[2] = 1'b0; req_data[23:16] = 8'h00;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Holds reset for two cycles with empty sources; caller releases reset_n.
  task automatic do_reset();
    reset_n   = 1'b0;
    ena       = 1'b1;
    out_ready = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    tick();
    tick();
    got_q.delete();
    glog_q.delete();
    trunc_cnt = 0;
  endtask

  // Runs until all sources are drained and the arbiter is idle, bounded.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size() != 0 || out_valid || busy) && n < 200) begin
      tick();
      n++;
    end
    tests_run++;
    if (n >= 200) begin
      tests_failed++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({out_valid, out_data, grant, busy, trunc_err, req_ready} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_values: valid=%b data=%h grant=%b busy=%b trunc=%b ready=%b, required all zero",
               out_valid, out_data, grant, busy, trunc_err, req_ready);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_packet();
    do_reset();
    q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42}); q0.push_back({1'b1, 8'h43});
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (grant !== 3'b000) begin
      tests_failed++; $display("FAIL single_pre_grant: got %b required 000", grant);
    end
    tick();
    tests_run++;
    if (grant !== 3'b001 || busy !== 1'b1 || req_ready !== 3'b001 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_grant: grant=%b busy=%b ready=%b valid=%b required 001 1 001 0",
               grant, busy, req_ready, out_valid);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h41) begin
      tests_failed++; $display("FAIL single_byte0: valid=%b data=%h required 1 41", out_valid, out_data);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h42) begin
      tests_failed++; $display("FAIL single_byte1: valid=%b data=%h required 1 42", out_valid, out_data);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h43 || grant !== 3'b000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_byte2: valid=%b data=%h grant=%b busy=%b required 1 43 000 0",
               out_valid, out_data, grant, busy);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_drain: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_two_requesters();
    int bad;
    do_reset();
    q0.push_back({1'b0, 8'h80}); q0.push_back({1'b1, 8'h81});
    q2.push_back({1'b0, 8'h90}); q2.push_back({1'b1, 8'h91});
    reset_n = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL two_idle_gap: grant=%b busy=%b required 000 0", grant, busy);
    end
    tick();
    tests_run++;
    if (grant !== 3'b100) begin
      tests_failed++; $display("FAIL two_second_grant: got %b required 100", grant);
    end
    wait_done("two");
    exp_q = '{8'h80, 8'h81, 8'h90, 8'h91};
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && bad == 0; i++) if (got_q[i] !== exp_q[i]) bad = 1;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL two_order: got %p required %p", got_q, exp_q);
    end
  endtask

  task automatic test_round_robin();
    int bad;
    do_reset();
    q0.push_back({1'b1, 8'h70}); q0.push_back({1'b1, 8'h73});
    q1.push_back({1'b1, 8'h71}); q1.push_back({1'b1, 8'h74});
    q2.push_back({1'b1, 8'h72}); q2.push_back({1'b1, 8'h75});
    reset_n = 1'b1;
    wait_done("rr");
    gexp_q = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    bad = (glog_q.size() != gexp_q.size()) ? 1 : 0;
    for (int i = 0; i < gexp_q.size() && bad == 0; i++) if (glog_q[i] !== gexp_q[i]) bad = 1;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL rr_grants: got %p required %p", glog_q, gexp_q);
    end
    exp_q = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && bad == 0; i++) if (got_q[i] !== exp_q[i]) bad = 1;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL rr_bytes: got %p required %p", got_q, exp_q);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    q1.push_back({1'b0, 8'hA0}); q1.push_back({1'b0, 8'hA1});
    q1.push_back({1'b0, 8'hA2}); q1.push_back({1'b1, 8'hA3});
    reset_n = 1'b1;
    tick();
    tick();
    tests_run++;
    if (grant !== 3'b010) begin
      tests_failed++; $display("FAIL bp_grant: got %b required 010", grant);
    end
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'hA0 || req_ready !== 3'b000) begin
        tests_failed++;
        $display("FAIL bp_stall%0d: valid=%b data=%h ready=%b required 1 a0 000",
                 c, out_valid, out_data, req_ready);
      end
    end
    out_ready = 1'b1;
    wait_done("bp");
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && bad == 0; i++) if (got_q[i] !== exp_q[i]) bad = 1;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL bp_bytes: got %p required %p", got_q, exp_q);
    end
    // Last byte coincides with the limit: clean end, no truncation.
    tests_run++;
    if (trunc_cnt != 0) begin
      tests_failed++; $display("FAIL bp_no_trunc: pulses=%0d required 0", trunc_cnt);
    end
  endtask

  task automatic test_truncation();
    int bad;
    do_reset();
    for (int i = 0; i < 5; i++) q1.push_back({1'b0, 8'(8'h20 + i)});
    q1.push_back({1'b1, 8'h25});
    reset_n = 1'b1;
    repeat (3) tick();
    q0.push_back({1'b1, 8'h30});
    tick();
    tests_run++;
    if (grant !== 3'b010 || req_ready[0] !== 1'b0) begin
      tests_failed++; $display("FAIL trunc_hold: grant=%b ready=%b required 010 x0x", grant, req_ready);
    end
    wait_done("trunc");
    tests_run++;
    if (trunc_cnt != 1) begin
      tests_failed++; $display("FAIL trunc_pulse: pulses=%0d required 1", trunc_cnt);
    end
    gexp_q = '{3'b010, 3'b001, 3'b010};
    bad = (glog_q.size() != gexp_q.size()) ? 1 : 0;
    for (int i = 0; i < gexp_q.size() && bad == 0; i++) if (glog_q[i] !== gexp_q[i]) bad = 1;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL trunc_grants: got %p required %p", glog_q, gexp_q);
    end
    exp_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h24, 8'h25};
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && bad == 0; i++) if (got_q[i] !== exp_q[i]) bad = 1;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL trunc_bytes: got %p required %p", got_q, exp_q);
    end
  endtask

  task automatic test_reset_mid_packet();
    int bad;
    do_reset();
    q0.push_back({1'b0, 8'hB0}); q0.push_back({1'b0, 8'hB1}); q0.push_back({1'b1, 8'hB2});
    q1.push_back({1'b1, 8'hC0});
    reset_n = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    tests_run++;
    if ({out_valid, out_data, grant, busy, trunc_err, req_ready} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midrst_values: valid=%b data=%h grant=%b busy=%b trunc=%b ready=%b, required all zero",
               out_valid, out_data, grant, busy, trunc_err, req_ready);
    end
    reset_n = 1'b1;
    tick();
    tests_run++;
    if (grant !== 3'b001) begin
      tests_failed++; $display("FAIL midrst_priority: got %b required 001", grant);
    end
    wait_done("midrst");
    exp_q = '{8'hB1, 8'hB2, 8'hC0};
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && bad == 0; i++) if (got_q[i] !== exp_q[i]) bad = 1;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL midrst_bytes: got %p required %p", got_q, exp_q);
    end
  endtask

  task automatic test_ena_freeze();
    int bad;
    do_reset();
    q2.push_back({1'b0, 8'h60}); q2.push_back({1'b0, 8'h61}); q2.push_back({1'b1, 8'h62});
    reset_n = 1'b1;
    repeat (3) tick();
    ena = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'h60 || req_ready !== 3'b000 || grant !== 3'b100 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL ena_freeze%0d: valid=%b data=%h ready=%b grant=%b busy=%b required 1 60 000 100 1",
                 c, out_valid, out_data, req_ready, grant, busy);
      end
    end
    ena = 1'b1;
    wait_done("ena");
    exp_q = '{8'h60, 8'h61, 8'h62};
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && bad == 0; i++) if (got_q[i] !== exp_q[i]) bad = 1;
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL ena_bytes: got %p required %p", got_q, exp_q);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    ena       = 1'b1;
    out_ready = 1'b1;
    test_reset();
    test_single_packet();
    test_two_requesters();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_reset_mid_packet();
    test_ena_freeze();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single UART TX FIFO write port between NUM_REQ byte-stream requesters, e.g. switch reporter, button reporter and RX echo. It sits in front of the TX FIFO's tx_data_in/tx_data_in_valid input. A granted requester keeps ownership until its packet ends, so bytes from different packets never interleave on the UART line. The output is registered, with one byte of storage.

Parameters:
DATA_WIDTH, 8, byte width of each requester and the output
NUM_REQ, 3, number of requesters (2..8)
MAX_PACKET_LEN, 16, maximum bytes per grant before forced release (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
ena  in  1  design enable; low freezes all state
req_data  in  NUM_REQ*DATA_WIDTH  requester bytes; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
req_valid  in  NUM_REQ  requester byte valid
req_last  in  NUM_REQ  marks the final byte of a packet
req_ready  out  NUM_REQ  byte accepted when req_valid[i] & req_ready[i]
out_data  out  DATA_WIDTH  byte to the TX FIFO
out_valid  out  1  out_data is valid
out_ready  in  1  TX FIFO accepts the byte (not full)
grant  out  NUM_REQ  one-hot current owner; all zeros when idle
busy  out  1  high while in GRANT
trunc_err  out  1  one-cycle pulse: packet force-released at MAX_PACKET_LEN

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n, and has priority over ena.
- Reset values:
  - state=IDLE
  - out_valid=0, out_data=0
  - grant=0, busy=0, trunc_err=0
  - byte counter=0
  - RR pointer=NUM_REQ-1, so requester 0 has first priority.
- ena=0: all registers hold, req_ready forced 0, out_valid holds its value. Consumers must ignore out_valid while ena=0.
- Output register:
  - Loads on a requester handshake.
  - Clears out_valid when out_valid&out_ready and there is no new load in the same cycle.
  - A simultaneous drain and load is allowed: full throughput of 1 byte/cycle.
  - out_data stays stable while out_valid=1 and out_ready=0.
- req_ready[i] = ena & (state==GRANT) & grant[i] & (~out_valid | out_ready). It is combinational and zero for all non-granted requesters.
- Latency: a requester handshake in cycle N gives out_valid with that byte in cycle N+1.
- FSM IDLE:
  - If any req_valid is set, pick the first index with req_valid set, searching from pointer+1 upward with wrap-around.
  - Next edge: grant=onehot(winner), pointer=winner, counter=0, state=GRANT, busy=1.
  - If no req_valid is set, stay in IDLE.
  - Arbitration costs 1 idle cycle between packets.
- FSM GRANT:
  - Each accepted byte increments the counter.
  - If the accepted byte has req_last=1, the packet ends.
  - If the counter reaches MAX_PACKET_LEN without last, the packet ends and trunc_err pulses for 1 cycle (the cycle after the accept).
  - On packet end: next edge state=IDLE, grant=0, busy=0. A byte still in the output register continues to drain independently.
- Last and limit coinciding: if req_last=1 on byte number MAX_PACKET_LEN, there is no trunc_err.
- MAX_PACKET_LEN=1: every byte is its own packet.
- The granted requester dropping req_valid mid-packet: grant is held and there is no timeout. Requesters must complete packets.
- Grant is never revoked early. Lower-priority requesters wait regardless of their req_last.
- Reset mid-packet: the packet is abandoned, the output byte is discarded (out_valid=0) and the pointer returns to NUM_REQ-1.
- Counter width is clog2(MAX_PACKET_LEN+1) bits; it never wraps.

Test Plan:
- Req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with out_ready=1 → grant=001 one cycle after req_valid; out_data 0x41,0x42,0x43 on consecutive cycles; grant=000 after the last accept.
- Req0 and req2 both valid from reset, 2-byte packets each → req0 served first, one idle cycle, then req2. Output order is req0 bytes, then req2 bytes, with no interleave.
- All 3 requesters continuously valid with 1-byte packets → grant sequence 0,1,2,0,1,2; each requester gets 1/3 of grants.
- out_ready held 0 for 5 cycles mid-packet → out_valid=1, out_data stable, req_ready=0. Release → bytes continue with none lost or duplicated; FIFO-model scoreboard matches.
- MAX_PACKET_LEN=4, req1 sends 6 bytes without last in the first 4 → force release after byte 4 with trunc_err pulse; req1 re-wins later and sends its remaining 2 bytes.
- reset_n low for 1 cycle mid-packet → all outputs at reset values next cycle; requester 0 has priority afterwards. ena=0 for 3 cycles mid-packet → state, out_data and out_valid are frozen and req_ready=0.
